// File: rtl/sccb_reg_target.sv
// ---------------------------------------------------------------------------
// sccb_reg_target
//   I2C/SCCB target holding a 2^REG_AW x 8-bit register bank. It accepts
//   3-byte writes (device address, sub-address, data), random reads and
//   current-address reads. It never stretches SCL.
//
//   Optional build macro: SCCB_TARGET_AUTOINC_EN
//     defined   - the sub-address pointer advances after every written byte
//                 and every ACKed read byte (burst access, wraps at the top)
//     undefined - the pointer changes only when a sub-address byte is received
//
// Ports
//   iCLK      system clock, at least 16x the SCL rate
//   iRST      synchronous active-high reset
//   iSCL      I2C clock from the pad (asynchronous)
//   iSDA      I2C data from the pad (asynchronous)
//   oSDA_OE   1 = pull SDA low, 0 = release (open-drain pad)
//   iRD_ADDR  host read address
//   oRD_DATA  bank[iRD_ADDR], one cycle of latency
//   oWR_STB   one-cycle pulse for each register written over I2C
//   oWR_ADDR  address of that write, valid with oWR_STB
//   oWR_DATA  data of that write, valid with oWR_STB
// ---------------------------------------------------------------------------
module sccb_reg_target #(
    parameter logic [6:0] DEV_ADDR = 7'h21,
    parameter int         REG_AW   = 8
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iSCL,
    input  logic              iSDA,
    output logic              oSDA_OE,
    input  logic [REG_AW-1:0] iRD_ADDR,
    output logic [7:0]        oRD_DATA,
    output logic              oWR_STB,
    output logic [REG_AW-1:0] oWR_ADDR,
    output logic [7:0]        oWR_DATA
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_SUB, S_SUB_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT_STOP
    } state_t;

    state_t            state, stateNext;
    logic              sclP0, sclP1, sclP2;
    logic              sdaP0, sdaP1, sdaP2;
    logic [2:0]        bitCnt, bitCntNext;
    logic [7:0]        shiftReg, shiftNext;
    logic              ackOn, ackOnNext;
    logic              rwBit, rwNext;
    logic              oeNext;
    logic [REG_AW-1:0] ptr, ptrNext, ptrAdv;
    logic              wrEn;
    logic [7:0]        bank [0:(1 << REG_AW)-1];

    logic       sclRise, sclFall, sclHigh, startCond, stopCond;
    logic [7:0] byteIn;

`ifdef SCCB_TARGET_AUTOINC_EN
    assign ptrAdv = ptr + {{(REG_AW-1){1'b0}}, 1'b1};
`else
    assign ptrAdv = ptr;
`endif

    // --- stage p0/p1: synchronise pads; p2: previous value for edge detect ---
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            // Idle bus levels, so leaving reset cannot fake a START.
            {sclP0, sclP1, sclP2} <= 3'b111;
            {sdaP0, sdaP1, sdaP2} <= 3'b111;
        end else begin
            {sclP0, sclP1, sclP2} <= {iSCL, sclP0, sclP1};
            {sdaP0, sdaP1, sdaP2} <= {iSDA, sdaP0, sdaP1};
        end
    end

    assign sclRise   = sclP1 & ~sclP2;
    assign sclFall   = ~sclP1 & sclP2;
    assign sclHigh   = sclP1 & sclP2;
    assign startCond = sclHigh & sdaP2 & ~sdaP1;
    assign stopCond  = sclHigh & ~sdaP2 & sdaP1;
    assign byteIn    = {shiftReg[6:0], sdaP1};

    // --- stage p3: protocol state register ---
    always_ff @(posedge iCLK) begin
        if (iRST) state <= S_IDLE;
        else      state <= stateNext;
    end

    always_comb begin
        stateNext  = state;
        bitCntNext = bitCnt;
        shiftNext  = shiftReg;
        ackOnNext  = ackOn;
        rwNext     = rwBit;
        oeNext     = oSDA_OE;
        ptrNext    = ptr;
        wrEn       = 1'b0;
        if (stopCond) begin
            stateNext = S_IDLE;
            oeNext    = 1'b0;
            ackOnNext = 1'b0;
        end else if (startCond) begin
            stateNext  = S_ADDR;
            bitCntNext = 3'd0;
            oeNext     = 1'b0;
            ackOnNext  = 1'b0;
        end else begin
            case (state)
                S_ADDR, S_SUB, S_WDATA: begin
                    if (sclRise) begin
                        shiftNext  = byteIn;
                        bitCntNext = bitCnt + 3'd1;
                        if (bitCnt == 3'd7) begin
                            if (state == S_ADDR) begin
                                rwNext    = sdaP1;
                                stateNext = (byteIn[7:1] == DEV_ADDR) ? S_ADDR_ACK : S_WAIT_STOP;
                            end else if (state == S_SUB) begin
                                ptrNext   = REG_AW'(byteIn);
                                stateNext = S_SUB_ACK;
                            end else begin
                                wrEn      = 1'b1;
                                ptrNext   = ptrAdv;
                                stateNext = S_WDATA_ACK;
                            end
                        end
                    end
                end
                // The first SCL fall starts the ACK low, the second ends it.
                S_ADDR_ACK, S_SUB_ACK, S_WDATA_ACK: begin
                    if (sclFall) begin
                        if (!ackOn) begin
                            oeNext    = 1'b1;
                            ackOnNext = 1'b1;
                        end else begin
                            ackOnNext  = 1'b0;
                            bitCntNext = 3'd0;
                            if (state == S_ADDR_ACK && rwBit) begin
                                // The read MSB goes out on the fall that ends the ACK.
                                shiftNext = bank[ptr];
                                oeNext    = ~bank[ptr][7];
                                stateNext = S_RDATA;
                            end else begin
                                oeNext    = 1'b0;
                                stateNext = (state == S_ADDR_ACK) ? S_SUB : S_WDATA;
                            end
                        end
                    end
                end
                S_RDATA: begin
                    if (sclRise) begin
                        shiftNext  = {shiftReg[6:0], 1'b0};
                        bitCntNext = bitCnt + 3'd1;
                        if (bitCnt == 3'd7) stateNext = S_RDATA_ACK;
                    end else if (sclFall) begin
                        oeNext = ~shiftReg[7];
                    end
                end
                S_RDATA_ACK: begin
                    if (sclFall) begin
                        oeNext = 1'b0;
                    end else if (sclRise) begin
                        if (!sdaP1) begin
                            ptrNext    = ptrAdv;
                            shiftNext  = bank[ptrAdv];
                            bitCntNext = 3'd0;
                            stateNext  = S_RDATA;
                        end else begin
                            stateNext = S_WAIT_STOP;
                        end
                    end
                end
                default: oeNext = 1'b0;
            endcase
        end
    end

    // --- stage p3: protocol datapath / control registers ---
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            bitCnt   <= 3'd0;
            shiftReg <= 8'h00;
            ackOn    <= 1'b0;
            rwBit    <= 1'b0;
            oSDA_OE  <= 1'b0;
            ptr      <= '0;
        end else begin
            bitCnt   <= bitCntNext;
            shiftReg <= shiftNext;
            ackOn    <= ackOnNext;
            rwBit    <= rwNext;
            oSDA_OE  <= oeNext;
            ptr      <= ptrNext;
        end
    end

    // --- stage p4: register bank, host read port and write strobe ---
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int i = 0; i < (1 << REG_AW); i++) bank[i] <= 8'h00;
            oRD_DATA <= 8'h00;
            oWR_STB  <= 1'b0;
            oWR_ADDR <= '0;
            oWR_DATA <= 8'h00;
        end else begin
            oRD_DATA <= bank[iRD_ADDR];
            oWR_STB  <= wrEn;
            if (wrEn) begin
                bank[ptr] <= byteIn;
                oWR_ADDR  <= ptr;
                oWR_DATA  <= byteIn;
            end
        end
    end

endmodule
